// File: rtl/display_pkg.sv
// Shared frame geometry, pixel format and buffer-state encoding for the
// double-buffered display controller.
package display_pkg;

   localparam int PIXEL_COUNT   = 256000;   // 640x400
   localparam int ADDRESS_WIDTH = 18;
   localparam int DATA_WIDTH    = 10;       // Y[9:6], Cb[5:3], Cr[2:0]

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_PENDING = 2'd1,
      ST_CLEAR   = 2'd2
   } buffer_state_t;

endpackage

// File: rtl/display_buffer_controller.sv
// Double-buffered frame store controller: graphics writes go to the back bank,
// the display reads the front bank, swaps happen on end-of-frame, then the new back bank is zeroed.
module display_buffer_controller #(
   parameter int PIXEL_COUNT   = display_pkg::PIXEL_COUNT,
   parameter int ADDRESS_WIDTH = display_pkg::ADDRESS_WIDTH,
   parameter int DATA_WIDTH    = display_pkg::DATA_WIDTH
) (
   input  logic                     clock_in,
   input  logic                     reset_n_in,
   input  logic [ADDRESS_WIDTH-1:0] write_address_in,
   input  logic [DATA_WIDTH-1:0]    write_data_in,
   input  logic                     write_enable_in,
   output logic                     write_ready_out,
   input  logic                     switch_request_in,
   output logic                     switch_pending_out,
   input  logic                     frame_complete_in,
   input  logic [ADDRESS_WIDTH-1:0] display_address_in,
   output logic [DATA_WIDTH-1:0]    display_data_out,
   output logic [ADDRESS_WIDTH-1:0] bank_a_address_out,
   output logic [DATA_WIDTH-1:0]    bank_a_write_data_out,
   output logic                     bank_a_write_enable_out,
   input  logic [DATA_WIDTH-1:0]    bank_a_read_data_in,
   output logic [ADDRESS_WIDTH-1:0] bank_b_address_out,
   output logic [DATA_WIDTH-1:0]    bank_b_write_data_out,
   output logic                     bank_b_write_enable_out,
   input  logic [DATA_WIDTH-1:0]    bank_b_read_data_in,
   output logic                     front_bank_out,
   output logic                     clearing_out
);
   import display_pkg::*;

   localparam logic [ADDRESS_WIDTH-1:0] LP_LAST_ADDR = ADDRESS_WIDTH'(PIXEL_COUNT - 1);

   buffer_state_t            r_state, w_state_next;
   logic                     r_front, w_front_next;
   logic                     r_front_d;
   logic [ADDRESS_WIDTH-1:0] r_clear_cnt, w_clear_cnt_next;
   logic                     r_req_latched, w_req_latched_next;
   logic [ADDRESS_WIDTH-1:0] r_wr_addr;
   logic [DATA_WIDTH-1:0]    r_wr_data;
   logic                     r_wr_en;

   logic                     w_swap;
   logic                     w_clear_last;
   logic                     w_addr_ok;
   logic                     w_write_accept;
   logic [ADDRESS_WIDTH-1:0] w_back_addr;
   logic [DATA_WIDTH-1:0]    w_back_data;
   logic                     w_back_we;

   assign w_clear_last   = (r_clear_cnt == LP_LAST_ADDR);
   assign w_addr_ok      = ({1'b0, write_address_in} < (ADDRESS_WIDTH + 1)'(PIXEL_COUNT));
   // A write in the swap cycle would land after the banks exchange roles, so it is discarded.
   assign w_write_accept = write_enable_in & write_ready_out & w_addr_ok & ~w_swap;

   always_comb begin
      w_state_next       = r_state;
      w_front_next       = r_front;
      w_clear_cnt_next   = r_clear_cnt;
      w_req_latched_next = r_req_latched;
      w_swap             = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (switch_request_in) begin
               w_state_next = ST_PENDING;
            end
         end
         ST_PENDING: begin
            if (frame_complete_in) begin
               w_swap           = 1'b1;
               w_front_next     = ~r_front;
               w_clear_cnt_next = '0;
               w_state_next     = ST_CLEAR;
            end
         end
         ST_CLEAR: begin
            if (switch_request_in) begin
               w_req_latched_next = 1'b1;
            end
            if (w_clear_last) begin
               w_clear_cnt_next   = '0;
               w_req_latched_next = 1'b0;
               w_state_next       = (r_req_latched | switch_request_in) ? ST_PENDING : ST_IDLE;
            end else begin
               w_clear_cnt_next = r_clear_cnt + ADDRESS_WIDTH'(1);
            end
         end
         default: begin
            w_state_next = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clock_in or negedge reset_n_in) begin
      if (!reset_n_in) begin
         r_state       <= ST_IDLE;
         r_front       <= 1'b0;
         r_front_d     <= 1'b0;
         r_clear_cnt   <= '0;
         r_req_latched <= 1'b0;
         r_wr_addr     <= '0;
         r_wr_data     <= '0;
         r_wr_en       <= 1'b0;
      end else begin
         r_state       <= w_state_next;
         r_front       <= w_front_next;
         r_front_d     <= r_front;
         r_clear_cnt   <= w_clear_cnt_next;
         r_req_latched <= w_req_latched_next;
         r_wr_en       <= w_write_accept;
         if (w_write_accept) begin
            r_wr_addr <= write_address_in;
            r_wr_data <= write_data_in;
         end
      end
   end

   assign write_ready_out    = (r_state != ST_CLEAR);
   assign switch_pending_out = (r_state == ST_PENDING);
   assign clearing_out       = (r_state == ST_CLEAR);
   assign front_bank_out     = r_front;

   // Clearing overrides the graphics path; the counter drives the back bank directly.
   assign w_back_addr = clearing_out ? r_clear_cnt : r_wr_addr;
   assign w_back_data = clearing_out ? '0 : r_wr_data;
   assign w_back_we   = clearing_out | r_wr_en;

   assign bank_a_address_out      = r_front ? w_back_addr : display_address_in;
   assign bank_a_write_data_out   = r_front ? w_back_data : '0;
   assign bank_a_write_enable_out = r_front & w_back_we;
   assign bank_b_address_out      = r_front ? display_address_in : w_back_addr;
   assign bank_b_write_data_out   = r_front ? '0 : w_back_data;
   assign bank_b_write_enable_out = ~r_front & w_back_we;

   // Read data lags the address by one cycle, so select with the bank that was front then.
   assign display_data_out = r_front_d ? bank_b_read_data_in : bank_a_read_data_in;

endmodule

// File: tb/tb_display_buffer_controller.sv
// Scoreboard bench for display_buffer_controller with a reduced frame size and
// behavioural 1-cycle-latency RAMs on both banks.
module tb_display_buffer_controller;

   localparam int PC = 40;
   localparam int AW = 8;
   localparam int DW = 10;

   typedef struct packed {
      logic          bank;
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [AW-1:0] wr_addr;
   logic [DW-1:0] wr_data;
   logic          wr_en;
   logic          wr_ready;
   logic          sw_req;
   logic          sw_pending;
   logic          fc;
   logic [AW-1:0] disp_addr;
   logic [DW-1:0] disp_data;
   logic [AW-1:0] a_addr, b_addr;
   logic [DW-1:0] a_wdata, b_wdata;
   logic          a_we, b_we;
   logic [DW-1:0] a_rdata, b_rdata;
   logic          front;
   logic          clearing;

   logic [DW-1:0] mem_a [256] = '{default: '0};
   logic [DW-1:0] mem_b [256] = '{default: '0};

   exp_t exp_q[$];
   int   tests  = 0;
   int   failed = 0;
   int   cyc;

   always #5 clk = ~clk;

   display_buffer_controller #(
      .PIXEL_COUNT  (PC),
      .ADDRESS_WIDTH(AW),
      .DATA_WIDTH   (DW)
   ) dut (
      .clock_in               (clk),
      .reset_n_in             (rst_n),
      .write_address_in       (wr_addr),
      .write_data_in          (wr_data),
      .write_enable_in        (wr_en),
      .write_ready_out        (wr_ready),
      .switch_request_in      (sw_req),
      .switch_pending_out     (sw_pending),
      .frame_complete_in      (fc),
      .display_address_in     (disp_addr),
      .display_data_out       (disp_data),
      .bank_a_address_out     (a_addr),
      .bank_a_write_data_out  (a_wdata),
      .bank_a_write_enable_out(a_we),
      .bank_a_read_data_in    (a_rdata),
      .bank_b_address_out     (b_addr),
      .bank_b_write_data_out  (b_wdata),
      .bank_b_write_enable_out(b_we),
      .bank_b_read_data_in    (b_rdata),
      .front_bank_out         (front),
      .clearing_out           (clearing)
   );

   always @(posedge clk) begin
      if (a_we) mem_a[a_addr] <= a_wdata;
      if (b_we) mem_b[b_addr] <= b_wdata;
      a_rdata <= mem_a[a_addr];
      b_rdata <= mem_b[b_addr];
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end else begin
         $display("[TB] ok   %s = 0x%0h", name, act);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_write(input logic [AW-1:0] addr, input logic [DW-1:0] data,
                           input logic bank, input logic accepted);
      wr_addr = addr;
      wr_data = data;
      wr_en   = 1'b1;
      if (accepted) exp_q.push_back('{bank, addr, data});
      $display("[TB] write addr=%0d data=0x%0h expect %s", addr, data,
               accepted ? (bank ? "bank_b" : "bank_a") : "dropped");
      tick();
      wr_en = 1'b0;
   endtask

   task automatic push_clear(input logic bank);
      for (int k = 0; k < PC; k++) exp_q.push_back('{bank, AW'(k), DW'(0)});
   endtask

   task automatic mon_write(input logic bank, input logic [AW-1:0] addr, input logic [DW-1:0] data);
      exp_t e;
      tests++;
      if (exp_q.size() == 0) begin
         failed++;
         $display("FAIL bank_write: unexpected write bank=%0d addr=%0d data=0x%0h, expected none",
                  bank, addr, data);
      end else begin
         e = exp_q.pop_front();
         if (e.bank !== bank || e.addr !== addr || e.data !== data) begin
            failed++;
            $display("FAIL bank_write: got bank=%0d addr=%0d data=0x%0h, expected bank=%0d addr=%0d data=0x%0h",
                     bank, addr, data, e.bank, e.addr, e.data);
         end
      end
   endtask

   always @(negedge clk) begin
      if (rst_n === 1'b1) begin
         if (a_we === 1'b1) mon_write(1'b0, a_addr, a_wdata);
         if (b_we === 1'b1) mon_write(1'b1, b_addr, b_wdata);
      end
   end

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish, expected completion");
      $fatal(1, "timeout");
   end

   initial begin
      rst_n = 1'b1; wr_addr = '0; wr_data = '0; wr_en = 1'b0;
      sw_req = 1'b0; fc = 1'b0; disp_addr = '0;
      #2 rst_n = 1'b0;
      #1;
      check("rst_front", 32'(front), 0);
      check("rst_pending", 32'(sw_pending), 0);
      check("rst_clearing", 32'(clearing), 0);
      check("rst_we_a", 32'(a_we), 0);
      check("rst_we_b", 32'(b_we), 0);
      check("rst_addr_b", 32'(b_addr), 0);
      check("rst_data_b", 32'(b_wdata), 0);
      repeat (2) tick();
      rst_n = 1'b1;
      check("ready_after_rst", 32'(wr_ready), 1);

      // First write: registered onto bank b one cycle later
      do_write(AW'(5), DW'(10'h3FF), 1'b1, 1'b1);
      check("wr5_we_b", 32'(b_we), 1);
      check("wr5_we_a", 32'(a_we), 0);
      check("wr5_addr_b", 32'(b_addr), 5);
      check("wr5_data_b", 32'(b_wdata), 32'h3FF);
      do_write(AW'(12), DW'(10'h155), 1'b1, 1'b1);
      do_write(AW'(39), DW'(10'h2AA), 1'b1, 1'b1);
      do_write(AW'(40), DW'(10'h1E1), 1'b1, 1'b0);

      // Request and frame end together in IDLE: pending only
      sw_req = 1'b1; fc = 1'b1;
      tick();
      sw_req = 1'b0; fc = 1'b0;
      check("same_cycle_pending", 32'(sw_pending), 1);
      check("same_cycle_front", 32'(front), 0);
      do_write(AW'(7), DW'(10'h011), 1'b1, 1'b1);
      repeat (100) tick();
      check("wait_pending", 32'(sw_pending), 1);
      check("wait_front", 32'(front), 0);

      // Swap to bank b, bank a gets cleared
      push_clear(1'b0);
      fc = 1'b1;
      tick();
      fc = 1'b0;
      check("swap1_front", 32'(front), 1);
      check("swap1_clearing", 32'(clearing), 1);
      check("swap1_ready", 32'(wr_ready), 0);
      cyc = 0;
      while (clearing && cyc < PC + 10) begin
         if (cyc == 10) begin
            wr_en = 1'b1; wr_addr = AW'(3); wr_data = DW'(10'h3C3);
            check("clear_ready", 32'(wr_ready), 0);
         end
         if (cyc == 20) sw_req = 1'b1;
         tick();
         wr_en = 1'b0; sw_req = 1'b0;
         cyc++;
      end
      check("clear1_cycles", 32'(cyc), PC);
      check("clear1_pending", 32'(sw_pending), 1);
      check("clear1_ready", 32'(wr_ready), 1);
      check("clear1_front", 32'(front), 1);
      do_write(AW'(9), DW'(10'h0F0), 1'b0, 1'b1);

      // Display reads from front bank b
      disp_addr = AW'(5);  tick(); check("rd_b5", 32'(disp_data), 32'h3FF);
      disp_addr = AW'(12); tick(); check("rd_b12", 32'(disp_data), 32'h155);
      disp_addr = AW'(39); tick(); check("rd_b39", 32'(disp_data), 32'h2AA);
      disp_addr = AW'(7);  tick(); check("rd_b7", 32'(disp_data), 32'h011);

      // Swap back to bank a; read in the swap cycle still comes from b
      disp_addr = AW'(9);
      push_clear(1'b1);
      fc = 1'b1;
      tick();
      fc = 1'b0;
      check("swap2_front", 32'(front), 0);
      check("swap2_old_front_rd", 32'(disp_data), 0);
      tick();
      check("swap2_new_front_rd", 32'(disp_data), 32'h0F0);
      cyc = 1;
      while (clearing && cyc < 20) begin
         tick();
         cyc++;
      end
      check("clear2_midway", 32'(clearing), 1);

      // Asynchronous reset mid-clear
      #2 rst_n = 1'b0;
      #1;
      exp_q.delete();
      check("arst_front", 32'(front), 0);
      check("arst_clearing", 32'(clearing), 0);
      check("arst_pending", 32'(sw_pending), 0);
      check("arst_we_a", 32'(a_we), 0);
      check("arst_we_b", 32'(b_we), 0);
      check("arst_addr_b", 32'(b_addr), 0);
      repeat (2) tick();
      rst_n = 1'b1;
      check("post_rst_ready", 32'(wr_ready), 1);
      fc = 1'b1;
      tick();
      fc = 1'b0;
      check("post_rst_fc_front", 32'(front), 0);
      check("post_rst_fc_clearing", 32'(clearing), 0);
      do_write(AW'(2), DW'(10'h0AA), 1'b1, 1'b1);
      repeat (3) tick();
      check("queue_drained", 32'(exp_q.size()), 0);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
